// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for an N-digit common-anode
// 7-segment hex display. A load is captured into shadow registers and only
// reaches the displayed value at a frame boundary, so a frame never mixes
// old and new digits. Every output is registered from the next-state values,
// so the digit select and the segment pattern change on the same edge.
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_blank_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_tick
);

    localparam int IDX_W  = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int CNT_W  = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

    // Active-low glyph for one hex nibble, segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // State registers
    logic                      running_r;   // low only on the first cycle out of reset
    logic [CNT_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          idx_r;
    logic [FCNT_W-1:0]         fcnt_r;
    logic                      phase_r;
    logic [4*NUM_DIGITS-1:0]   shadow_val_r;
    logic [NUM_DIGITS-1:0]     shadow_dp_r;
    logic [4*NUM_DIGITS-1:0]   disp_val_r;
    logic [NUM_DIGITS-1:0]     disp_dp_r;

    // Next-state values
    logic [CNT_W-1:0]          next_cnt_s;
    logic [IDX_W-1:0]          next_idx_s;
    logic                      boundary_s;
    logic [FCNT_W-1:0]         next_fcnt_s;
    logic                      next_phase_s;
    logic [4*NUM_DIGITS-1:0]   next_disp_val_s;
    logic [NUM_DIGITS-1:0]     next_disp_dp_s;

    // Output decode values
    logic [3:0]                nib_s;
    logic                      seen_nz_s;
    logic                      lz_cur_s;
    logic                      dp_bit_s;
    logic                      blink_bit_s;
    logic [NUM_DIGITS-1:0]     an_s;
    logic [6:0]                seg_s;
    logic                      dp_s;

    // Refresh counter, digit index and frame-boundary detection; the first
    // cycle after reset only lights digit 0 so it gets a full REFRESH_DIV.
    always_comb begin
        next_cnt_s = cnt_r;
        next_idx_s = idx_r;
        boundary_s = 1'b0;
        if (!running_r) begin
            next_cnt_s = cnt_r;
            next_idx_s = idx_r;
        end else if (cnt_r == CNT_MAX) begin
            next_cnt_s = {CNT_W{1'b0}};
            if (idx_r == IDX_MAX) begin
                next_idx_s = {IDX_W{1'b0}};
                boundary_s = 1'b1;
            end else begin
                next_idx_s = idx_r + IDX_W'(1);
            end
        end else begin
            next_cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // Display value update at frame boundaries, with load bypass, and blink timing.
    always_comb begin
        next_disp_val_s = disp_val_r;
        next_disp_dp_s  = disp_dp_r;
        next_fcnt_s     = fcnt_r;
        next_phase_s    = phase_r;
        if (boundary_s) begin
            if (load) begin
                next_disp_val_s = value_in;
                next_disp_dp_s  = dp_in;
            end else begin
                next_disp_val_s = shadow_val_r;
                next_disp_dp_s  = shadow_dp_r;
            end
            if (fcnt_r == FCNT_MAX) begin
                next_fcnt_s  = {FCNT_W{1'b0}};
                next_phase_s = ~phase_r;
            end else begin
                next_fcnt_s  = fcnt_r + FCNT_W'(1);
            end
        end else begin
            next_fcnt_s  = fcnt_r;
            next_phase_s = phase_r;
        end
    end

    // Select the next digit, apply leading-zero and blink blanking, build outputs.
    always_comb begin
        nib_s       = 4'd0;
        seen_nz_s   = 1'b0;
        lz_cur_s    = 1'b0;
        dp_bit_s    = 1'b0;
        blink_bit_s = 1'b0;
        an_s        = {NUM_DIGITS{1'b1}};
        seg_s       = 7'h7F;
        dp_s        = 1'b1;
        // Walk from the most significant digit; a digit is a leading zero
        // while no nonzero digit has been seen above or at it.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (next_disp_val_s[4*i +: 4] != 4'd0) begin
                seen_nz_s = 1'b1;
            end else begin
                seen_nz_s = seen_nz_s;
            end
            if (IDX_W'(i) == next_idx_s) begin
                an_s[i]     = 1'b0;
                nib_s       = next_disp_val_s[4*i +: 4];
                lz_cur_s    = lz_blank_en & ~seen_nz_s & (i != 0);
                dp_bit_s    = next_disp_dp_s[i];
                blink_bit_s = blink_mask[i];
            end else begin
                an_s[i]     = 1'b1;
            end
        end
        if (next_phase_s && blink_bit_s) begin
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end else if (lz_cur_s) begin
            seg_s = 7'h7F;
            dp_s  = ~dp_bit_s;
        end else begin
            seg_s = hex_glyph(nib_s);
            dp_s  = ~dp_bit_s;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_r    <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            fcnt_r       <= {FCNT_W{1'b0}};
            phase_r      <= 1'b0;
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            seg_n        <= 7'h7F;
            dp_n         <= 1'b1;
            an_n         <= {NUM_DIGITS{1'b1}};
            frame_tick   <= 1'b0;
        end else begin
            running_r  <= 1'b1;
            cnt_r      <= next_cnt_s;
            idx_r      <= next_idx_s;
            fcnt_r     <= next_fcnt_s;
            phase_r    <= next_phase_s;
            disp_val_r <= next_disp_val_s;
            disp_dp_r  <= next_disp_dp_s;
            if (load) begin
                shadow_val_r <= value_in;
                shadow_dp_r  <= dp_in;
            end
            seg_n      <= seg_s;
            dp_n       <= dp_s;
            an_n       <= an_s;
            frame_tick <= boundary_s;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (4 digits, 4 cycles per digit, 2 frames per
// blink half-period). A reference model derives every output from elapsed
// time since reset release: digit = (t/R)%N, frame = t/(N*R), blink phase =
// (frame/BF)%2, with the displayed value latched at each frame start.
module tb_hex_display_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int BF = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [4*N-1:0]  value_in;
    logic [N-1:0]    dp_in;
    logic            lz_blank_en;
    logic [N-1:0]    blink_mask;
    logic [6:0]      seg_n;
    logic            dp_n;
    logic [N-1:0]    an_n;
    logic            frame_tick;

    hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
        .lz_blank_en(lz_blank_en), .blink_mask(blink_mask),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [6:0]  font [16];
    bit          m_run;
    int          m_t;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sdp, m_ddp;
    int          m_digit;
    int          last_tick_t;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp_v, m_t);
        end
    endtask

    // One clock: update the model with the inputs sampled at this edge, then
    // compare every output shortly after the edge.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_tick, lz, blink;
        int         frame, phase;
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_t = 0; m_shadow = 16'h0; m_sdp = 4'h0;
            m_disp = 16'h0; m_ddp = 4'h0; m_digit = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
            if (load) begin m_shadow = value_in; m_sdp = dp_in; end
            e_tick = (m_t > 0) && (m_t % (N*R) == 0);
            if (e_tick) begin m_disp = m_shadow; m_ddp = m_sdp; end
            m_digit = (m_t / R) % N;
            frame   = m_t / (N*R);
            phase   = (frame / BF) % 2;
            e_an    = ~(4'b0001 << m_digit);
            lz      = lz_blank_en && (m_digit != 0) && ((m_disp >> (4*m_digit)) == 16'h0);
            blink   = (phase == 1) && blink_mask[m_digit];
            e_seg   = blink ? 7'h7F : (lz ? 7'h7F : font[(m_disp >> (4*m_digit)) & 16'hF]);
            e_dp    = blink ? 1'b1 : ~m_ddp[m_digit];
        end
        #1;
        chk("an_n",       {12'd0, an_n},       {12'd0, e_an});
        chk("seg_n",      {9'd0, seg_n},       {9'd0, e_seg});
        chk("dp_n",       {15'd0, dp_n},       {15'd0, e_dp});
        chk("frame_tick", {15'd0, frame_tick}, {15'd0, e_tick});
        if (frame_tick && !rst) begin
            if (last_tick_t >= 0) chk("tick_period", 16'(m_t - last_tick_t), 16'(N*R));
            last_tick_t = m_t;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance until the DUT raises frame_tick, bounded by one frame plus margin.
    task automatic wait_frame();
        bit seen = 0;
        for (int k = 0; k < 2*N*R && !seen; k++) begin
            tick();
            seen = frame_tick;
        end
        chk("frame_tick_timeout", {15'd0, seen}, 16'd1);
    endtask

    // Advance until the model is at the given cycle offset within a frame.
    task automatic wait_phase(input int pos);
        for (int k = 0; k < N*R && (m_t % (N*R)) != pos; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
        tick();
        load = 1'b0;
    endtask

    initial begin
        font[0]  = 7'h40; font[1]  = 7'h79; font[2]  = 7'h24; font[3]  = 7'h30;
        font[4]  = 7'h19; font[5]  = 7'h12; font[6]  = 7'h02; font[7]  = 7'h78;
        font[8]  = 7'h00; font[9]  = 7'h10; font[10] = 7'h08; font[11] = 7'h03;
        font[12] = 7'h46; font[13] = 7'h21; font[14] = 7'h06; font[15] = 7'h0E;
        last_tick_t = -1;
        m_t = 0; m_digit = 0;
        rst = 1'b1; load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
        lz_blank_en = 1'b0; blink_mask = 4'h0;

        // Reset state
        run(3);
        chk("reset_an", {12'd0, an_n}, 16'h000F);

        // Reset release and plain scan
        rst = 1'b0;
        tick();
        chk("start_an", {12'd0, an_n}, 16'h000E);
        chk("start_seg", {9'd0, seg_n}, 16'h0040);
        run(40);

        // Mid-frame load: current frame keeps 0, next frame shows 1A3F
        wait_phase(5);
        do_load(16'h1A3F, 4'h0);
        chk("old_frame_seg", {9'd0, seg_n}, 16'h0040);
        wait_frame();
        chk("ld_d0", {9'd0, seg_n}, 16'h000E);
        run(R); chk("ld_d1", {9'd0, seg_n}, 16'h0030);
        run(R); chk("ld_d2", {9'd0, seg_n}, 16'h0008);
        run(R); chk("ld_d3", {9'd0, seg_n}, 16'h0079);

        // Leading-zero blanking
        lz_blank_en = 1'b1;
        do_load(16'h0005, 4'h0);
        wait_frame();
        chk("lz5_d0", {9'd0, seg_n}, 16'h0012);
        run(R); chk("lz5_d1", {9'd0, seg_n}, 16'h007F);
        run(2*R); chk("lz5_d3", {9'd0, seg_n}, 16'h007F);
        do_load(16'h0000, 4'h0);
        wait_frame();
        chk("lz0_d0", {9'd0, seg_n}, 16'h0040);
        run(R); chk("lz0_d1", {9'd0, seg_n}, 16'h007F);
        lz_blank_en = 1'b0;

        // Load coincident with the frame boundary takes effect immediately
        wait_phase(15);
        do_load(16'h00C0, 4'h0);
        chk("bypass_tick", {15'd0, frame_tick}, 16'd1);
        run(R); chk("bypass_d1", {9'd0, seg_n}, 16'h0046);

        // Blink on digit 0 with its decimal point
        blink_mask = 4'b0001;
        do_load(16'h0000, 4'b0001);
        run(6*N*R);
        blink_mask = 4'b0000;

        // Randomized operation
        for (int k = 0; k < 400; k++) begin
            load        = ($urandom_range(0, 7) == 0);
            value_in    = 16'($urandom);
            dp_in       = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_blank_en = 1'($urandom);
            if ($urandom_range(0, 31) == 0) blink_mask  = 4'($urandom);
            tick();
        end
        load = 1'b0;

        // Reset during digit 2 with a pending load
        wait_phase(9);
        do_load(16'hBEEF, 4'hF);
        rst = 1'b1;
        tick();
        chk("midrst_an", {12'd0, an_n}, 16'h000F);
        chk("midrst_seg", {9'd0, seg_n}, 16'h007F);
        rst = 1'b0;
        last_tick_t = -1;
        lz_blank_en = 1'b0; blink_mask = 4'h0;
        run(2*N*R + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
